// File: rtl/pkt_buffer_pkg.sv
// Shared types and width helpers for the packet store-and-forward buffer.
// Default geometry lives here so the top and the bench agree on it.
package pkt_buffer_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_DEF   = 64;
    localparam int MAX_PKT_DEF = 16;
    localparam int PKT_Q_DEF   = 4;

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_t;
    typedef enum logic       {R_IDLE, R_SEND}        rd_state_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int len_width(input int max_pkt);
        return $clog2(max_pkt + 1);
    endfunction

endpackage

// File: rtl/len_fifo.sv
// Committed-length queue: synchronous FIFO, head word visible combinationally.
// Zero-latency head; a push while full or a pop while empty is ignored.
module len_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                     clk_hifreq,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign pop_dat = mem[rd_idx_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        if (do_push) wr_idx_d = wr_idx_q + IW'(1);
        if (do_pop)  rd_idx_d = rd_idx_q + IW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (IW+1)'(1);
            2'b01:   cnt_d = cnt_q - (IW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_hifreq) begin
        if (!rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_hifreq) begin
        if (do_push) mem[wr_idx_q] <= push_dat;
    end

endmodule

// File: rtl/pkt_buffer.sv
// Packet store-and-forward buffer: stores framed words, replays committed packets.
// Commit-to-first-valid is 2 cycles; output stalls on out_ready, input throttled via rdy.
module pkt_buffer
    import pkt_buffer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MAX_PKT = MAX_PKT_DEF,
    parameter int PKT_Q   = PKT_Q_DEF
) (
    input  logic              clk_hifreq,
    input  logic              rst,
    input  logic              sop,
    input  logic              eop,
    input  logic              wren,
    input  logic [DATA_W-1:0] datain,
    output logic              rdy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              drop_pulse,
    output logic [15:0]       drop_cnt
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam int LEN_W = len_width(MAX_PKT);
    localparam int CNT_W = $clog2(PKT_Q) + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    wr_state_t         wr_state_q, wr_state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  pkt_start_q, pkt_start_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;

    rd_state_t         rd_state_q, rd_state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              rdy_q, rdy_d;
    logic              drop_pulse_q, drop_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_wptr;
    logic [PTR_W-1:0]  wr_base, rd_next, occ, free_words;
    logic              mem_full;
    logic              q_push, q_pop, q_full, q_empty;
    logic [LEN_W-1:0]  q_head;
    logic [CNT_W-1:0]  q_cnt;

    len_fifo #(.DEPTH(PKT_Q), .W(LEN_W)) u_len_q (
        .clk_hifreq (clk_hifreq),
        .rst        (rst),
        .push       (q_push),
        .push_dat   (len_d),
        .pop        (q_pop),
        .pop_dat    (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_cnt)
    );

    assign occ        = wr_ptr_q - rd_ptr_q;
    assign free_words = PTR_W'(DEPTH) - occ;
    assign mem_full   = (occ == PTR_W'(DEPTH));
    assign wr_base    = (wr_state_q == W_PKT) ? pkt_start_q : wr_ptr_q;
    assign rd_next    = rd_ptr_q + PTR_W'(1);
    assign rdy_d      = (free_words >= PTR_W'(MAX_PKT)) && (q_cnt < CNT_W'(PKT_Q));
    assign drop_cnt_d = (drop_d && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_ptr_d     = wr_ptr_q;
        pkt_start_d  = pkt_start_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        mem_we       = 1'b0;
        mem_wptr     = wr_ptr_q;
        drop_d       = 1'b0;
        q_push       = 1'b0;
        if (wren) begin
            if (sop && (wr_state_q == W_PKT || !mem_full)) begin
                // A sop inside a packet abandons it and restarts at the same base.
                drop_d      = (wr_state_q == W_PKT);
                mem_we      = 1'b1;
                mem_wptr    = wr_base;
                pkt_start_d = wr_base;
                len_d       = LEN_W'(1);
                wr_ptr_d    = wr_base + PTR_W'(1);
                wr_state_d  = W_PKT;
                if (eop) begin
                    wr_state_d = W_IDLE;
                    if (q_full) begin
                        drop_d   = 1'b1;
                        wr_ptr_d = wr_base;
                    end else begin
                        q_push       = 1'b1;
                        commit_ptr_d = wr_base + PTR_W'(1);
                    end
                end
            end else if (sop) begin
                drop_d     = 1'b1;
                wr_state_d = eop ? W_IDLE : W_DROP;
            end else if (wr_state_q == W_PKT) begin
                if (len_q == LEN_W'(MAX_PKT) || mem_full) begin
                    drop_d     = 1'b1;
                    wr_ptr_d   = pkt_start_q;
                    wr_state_d = eop ? W_IDLE : W_DROP;
                end else begin
                    mem_we   = 1'b1;
                    len_d    = len_q + LEN_W'(1);
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (eop) begin
                        wr_state_d = W_IDLE;
                        if (q_full) begin
                            drop_d   = 1'b1;
                            wr_ptr_d = pkt_start_q;
                        end else begin
                            q_push       = 1'b1;
                            commit_ptr_d = wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
            end else if (wr_state_q == W_DROP && eop) begin
                wr_state_d = W_IDLE;
            end
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        rd_len_d    = rd_len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        q_pop       = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (!q_empty && rd_ptr_q != commit_ptr_q) begin
                    q_pop       = 1'b1;
                    rd_len_d    = q_head;
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b1;
                    out_eop_d   = (q_head == LEN_W'(1));
                    out_data_d  = mem[rd_ptr_q[AW-1:0]];
                    rd_state_d  = R_SEND;
                end
            end
            R_SEND: begin
                if (out_valid_q && out_ready) begin
                    rd_ptr_d = rd_next;
                    rd_len_d = rd_len_q - LEN_W'(1);
                    if (rd_len_q == LEN_W'(1)) begin
                        // Chain straight into the next committed packet without a bubble.
                        if (!q_empty && rd_next != commit_ptr_q) begin
                            q_pop      = 1'b1;
                            rd_len_d   = q_head;
                            out_sop_d  = 1'b1;
                            out_eop_d  = (q_head == LEN_W'(1));
                            out_data_d = mem[rd_next[AW-1:0]];
                        end else begin
                            out_valid_d = 1'b0;
                            out_sop_d   = 1'b0;
                            out_eop_d   = 1'b0;
                            rd_state_d  = R_IDLE;
                        end
                    end else begin
                        out_sop_d  = 1'b0;
                        out_eop_d  = (rd_len_q == LEN_W'(2));
                        out_data_d = mem[rd_next[AW-1:0]];
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_hifreq) begin
        if (!rst) begin
            wr_state_q   <= W_IDLE;
            wr_ptr_q     <= '0;
            pkt_start_q  <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
            rd_state_q   <= R_IDLE;
            rd_ptr_q     <= '0;
            rd_len_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            rdy_q        <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_ptr_q     <= wr_ptr_d;
            pkt_start_q  <= pkt_start_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
            rd_state_q   <= rd_state_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_len_q     <= rd_len_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            rdy_q        <= rdy_d;
            drop_pulse_q <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_hifreq) begin
        if (mem_we) mem[mem_wptr[AW-1:0]] <= datain;
    end

    assign rdy        = rdy_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_buffer.sv
// Directed bench for pkt_buffer: per-cycle vector table plus multi-cycle sequences.
module tb_pkt_buffer;

    logic        clk;
    logic        rst;
    logic        sop, eop, wren;
    logic [31:0] datain;
    logic        rdy, out_valid, out_ready, out_sop, out_eop, drop_pulse;
    logic [31:0] out_data;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int drops = 0;
    logic [31:0] got_dat [$];
    logic        got_sop [$];
    logic        got_eop [$];

    pkt_buffer dut (
        .clk_hifreq (clk),
        .rst        (rst),
        .sop        (sop),
        .eop        (eop),
        .wren       (wren),
        .datain     (datain),
        .rdy        (rdy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output beats and drop pulses are recorded mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_dat.push_back(out_data);
            got_sop.push_back(out_sop);
            got_eop.push_back(out_eop);
        end
        if (drop_pulse) drops++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst, sop, eop, wren;
        logic [31:0] din;
        logic        ordy;
        logic        e_vld;
        logic [31:0] e_dat;
        logic        e_sop, e_eop, e_rdy, e_drop;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic s, input logic e, input logic [31:0] d);
        sop = s; eop = e; wren = 1'b1; datain = d;
        tick(1);
        sop = 1'b0; eop = 1'b0; wren = 1'b0; datain = '0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int len);
        for (int i = 0; i < len; i++)
            send_word(i == 0, i == len - 1, base + 32'(i));
    endtask

    task automatic clear_log();
        got_dat.delete(); got_sop.delete(); got_eop.delete();
        drops = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0; sop = 1'b0; eop = 1'b0; wren = 1'b0; datain = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
        clear_log();
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got_dat.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (got_dat.size() < n) begin
            n_bad++;
            $display("FAIL wait_got: collected %0d words, expected %0d", got_dat.size(), n);
        end
    endtask

    task automatic check_beats(input string nm, input logic [31:0] base, input int len, input int pkt);
        check({nm, " beat count"}, 32'(got_dat.size()), 32'(len));
        for (int k = 0; k < len && k < got_dat.size(); k++) begin
            check($sformatf("%s data[%0d]", nm, k), got_dat[k], base + 32'(k));
            check($sformatf("%s sop[%0d]", nm, k), 32'(got_sop[k]), 32'((k % pkt) == 0));
            check($sformatf("%s eop[%0d]", nm, k), 32'(got_eop[k]), 32'((k % pkt) == pkt - 1));
        end
    endtask

    initial begin
        rst = 1'b0; sop = 1'b0; eop = 1'b0; wren = 1'b0; datain = '0; out_ready = 1'b1;

        //              rst  sop  eop  wren din           ordy vld  dat          sop  eop  rdy  drop cnt
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b0,16'd0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,32'hDEAD,     1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b1,32'hA0,       1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,32'hA1,       1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,32'hA2,       1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b1,32'hA3,       1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'hA0,      1'b1,1'b0,1'b1,1'b0,16'd0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'hA1,      1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'hA1,      1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'hA2,      1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'hA3,      1'b0,1'b1,1'b1,1'b0,16'd0};
        vecs[11] = '{1'b1,1'b1,1'b1,1'b1,32'h55,       1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h55,      1'b1,1'b1,1'b1,1'b0,16'd0};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,1'b0,16'd0};

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; sop = vecs[i].sop; eop = vecs[i].eop; wren = vecs[i].wren;
            datain = vecs[i].din; out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            check($sformatf("v%0d out_sop", i), 32'(out_sop), 32'(vecs[i].e_sop));
            check($sformatf("v%0d out_eop", i), 32'(out_eop), 32'(vecs[i].e_eop));
            check($sformatf("v%0d rdy", i), 32'(rdy), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d drop_pulse", i), 32'(drop_pulse), 32'(vecs[i].e_drop));
            check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_cnt));
            if (vecs[i].e_vld)
                check($sformatf("v%0d out_data", i), out_data, vecs[i].e_dat);
            if (i == 0)
                check("v0 out_data reset", out_data, 32'h0);
        end
        sop = 1'b0; eop = 1'b0; wren = 1'b0; out_ready = 1'b1;

        // Oversize packet is dropped on word 17, the next packet is intact.
        do_reset();
        send_pkt(32'h100, 17);
        send_pkt(32'h200, 2);
        tick(8);
        check("oversize drop pulses", 32'(drops), 32'd1);
        check("oversize drop_cnt", 32'(drop_cnt), 32'd1);
        check_beats("after oversize", 32'h200, 2, 2);

        // sop on the third word abandons the first packet and restarts there.
        do_reset();
        send_word(1'b1, 1'b0, 32'h300);
        send_word(1'b0, 1'b0, 32'h301);
        send_pkt(32'h310, 3);
        tick(8);
        check("abort drop_cnt", 32'(drop_cnt), 32'd1);
        check_beats("restart", 32'h310, 3, 3);

        // Fill with output stalled: memory fills after four packets, fifth is dropped.
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(32'h1000 + 32'(p * 16), 16);
        tick(1);
        check("full rdy low", 32'(rdy), 32'd0);
        send_pkt(32'h1040, 16);
        tick(3);
        check("full drop_cnt", 32'(drop_cnt), 32'd1);
        check("stalled no beats", 32'(got_dat.size()), 32'd0);
        check("stalled out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_got(64, 300);
        tick(5);
        check_beats("drain", 32'h1000, 64, 16);
        check("drain rdy back", 32'(rdy), 32'd1);
        check("drain idle", 32'(out_valid), 32'd0);

        // Reset in the middle of an output packet discards everything silently.
        do_reset();
        send_pkt(32'h400, 4);
        wait_got(2, 50);
        rst = 1'b0;
        tick(1);
        check("mid-reset out_valid", 32'(out_valid), 32'd0);
        check("mid-reset out_sop", 32'(out_sop), 32'd0);
        check("mid-reset rdy", 32'(rdy), 32'd0);
        rst = 1'b1;
        clear_log();
        tick(4);
        check("post-reset queue empty", 32'(out_valid), 32'd0);
        check("post-reset drop_cnt", 32'(drop_cnt), 32'd0);
        check("post-reset no drop", 32'(drops), 32'd0);
        send_pkt(32'h500, 4);
        wait_got(4, 50);
        tick(3);
        check_beats("post-reset pkt", 32'h500, 4, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
